// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART sizing constants
// Purpose: character width and FIFO depth used by the UART FIFOs,
//          the top-level integration and the benches.
package uart_pkg;

   localparam int MAX_UART_DATA_W = 8;
   localparam int UART_DATA_W     = 8;
   localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through character FIFO for the UART TX/RX paths
// Purpose: DEPTH x DATA_W register FIFO with occupancy count, level flags
//          and sticky overflow/underflow flags.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   clear_i        synchronous flush of pointers, count and sticky flags
//   push_i/data_i  write request and write data
//   pop_i          read request
//   data_o         head entry (valid while empty_o=0)
//   empty_o/full_o/almost_full_o  level flags from the registered count
//   count_o        current occupancy
//   overflow_o     sticky: a push was rejected
//   underflow_o    sticky: a pop was rejected
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W          = UART_DATA_W,
   parameter int DEPTH           = UART_FIFO_DEPTH,
   parameter int ALMOST_FULL_LVL = DEPTH - 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int                ADDR_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   LP_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LP_AF   = (ADDR_W+1)'(ALMOST_FULL_LVL);
   localparam logic [ADDR_W:0]   LP_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LP_INC  = ADDR_W'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;
   logic              r_underflow;

   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;
   logic w_flush;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == LP_FULL);
   assign w_flush   = rst_i | clear_i;
   assign w_pop_ok  = pop_i & ~w_empty;
   // A full FIFO still takes a push when the same edge frees the head slot.
   assign w_push_ok = push_i & (~w_full | w_pop_ok);

   // Storage is deliberately not reset; only the bookkeeping is.
   always_ff @(posedge clk_i) begin
      if (!w_flush && w_push_ok) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + LP_INC;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + LP_INC;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + LP_ONE;
            2'b01:   r_count <= r_count - LP_ONE;
            default: r_count <= r_count;
         endcase
         if (push_i && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
         if (pop_i && !w_pop_ok) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign data_o        = r_mem[r_rd_ptr];
   assign empty_o       = w_empty;
   assign full_o        = w_full;
   assign almost_full_o = (r_count >= LP_AF);
   assign count_o       = r_count;
   assign overflow_o    = r_overflow;
   assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - scoreboard bench for uart_fifo
module tb_uart_fifo;
   import uart_pkg::*;

   localparam int DEPTH = UART_FIFO_DEPTH;
   localparam int AF    = DEPTH - 2;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       push_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       pop_i = 1'b0;
   logic [7:0] data_o;
   logic       empty_o;
   logic       full_o;
   logic       almost_full_o;
   logic [4:0] count_o;
   logic       overflow_o;
   logic       underflow_o;

   uart_fifo dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .push_i        (push_i),
      .data_i        (data_i),
      .pop_i         (pop_i),
      .data_o        (data_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .count_o       (count_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   int         n_checks = 0;
   int         n_fails  = 0;
   logic [7:0] sb[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = sb.size();
      check({tag, ".count"}, 32'(count_o), 32'(n));
      check({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
      check({tag, ".full"},  32'(full_o),  32'(n == DEPTH));
      check({tag, ".af"},    32'(almost_full_o), 32'(n >= AF));
      check({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
      check({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
   endtask

   // One clock of push/pop; head data is compared just before the edge.
   task automatic step(input logic p, input logic [7:0] d, input logic q);
      logic pop_ok;
      logic push_ok;
      push_i = p;
      data_i = d;
      pop_i  = q;
      @(negedge clk_i);
      pop_ok = q && (sb.size() > 0);
      if (pop_ok) begin
         check("pop_data", 32'(data_o), 32'(sb.pop_front()));
      end else if (q) begin
         m_unf = 1'b1;
      end
      push_ok = p && ((sb.size() + (pop_ok ? 1 : 0)) <= DEPTH - 1 || pop_ok);
      if (push_ok) sb.push_back(d);
      else if (p) m_ovf = 1'b1;
      @(posedge clk_i);
      #1;
      push_i = 1'b0;
      pop_i  = 1'b0;
   endtask

   // Reset or clear cycle with a push attempt that must be ignored.
   task automatic flush(input logic r, input logic c);
      rst_i   = r;
      clear_i = c;
      push_i  = 1'b1;
      data_i  = 8'h99;
      @(posedge clk_i);
      #1;
      rst_i   = 1'b0;
      clear_i = 1'b0;
      push_i  = 1'b0;
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   initial begin
      logic [7:0] pat[3];
      pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'h0F;

      @(posedge clk_i);
      #1;
      flush(1'b1, 1'b0);
      check_state("reset");

      for (int i = 0; i < 3; i++) step(1'b1, pat[i], 1'b0);
      check_state("three_pushed");
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      check_state("three_popped");

      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
      check_state("filled");
      step(1'b1, 8'hFF, 1'b0);
      check_state("overflow");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
      check_state("drained_no_ff");

      flush(1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b1, 8'hA5, 1'b1);
      check_state("full_push_pop");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
      check_state("full_push_pop_drain");

      flush(1'b0, 1'b1);
      step(1'b1, 8'h3C, 1'b1);
      check_state("empty_push_pop");
      check("empty_push_pop.data", 32'(data_o), 32'h3C);
      step(1'b0, 8'h00, 1'b1);

      flush(1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b0);
         check("af_level", 32'(almost_full_o), 32'(i + 1 >= AF));
      end
      for (int i = 15; i < 20; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b1);
         check_state("wrap_both");
      end
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 8'h00, 1'b1);
         check("af_drain", 32'(almost_full_o), 32'(sb.size() >= AF));
      end
      check_state("wrap_drained");

      flush(1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      check_state("pre_reset");
      flush(1'b1, 1'b0);
      check_state("mid_reset");
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
      step(1'b1, 8'h00, 1'b1);
      flush(1'b0, 1'b1);
      check_state("clear");
      step(1'b1, 8'h77, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check_state("after_clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
